// File: rtl/vga_plot_framebuffer.sv
// vga_plot_framebuffer: 160x120x3 plot framebuffer, scanned out as 640x480@60 VGA with 4x4 pixel replication.
// Build macro PLOT_CLIP_EN: when defined, plots outside the 160x120 field are discarded.
`timescale 1ns/1ps
module vga_plot_framebuffer #(
  parameter int X_SCREEN_PIXELS = 160,
  parameter int Y_SCREEN_PIXELS = 120,
  parameter int SCALE_SHIFT     = 2,
  parameter int H_VIS           = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_VIS           = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  output logic       vga_clk,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       frame_start
);

  localparam int         H_TOTAL   = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int         V_TOTAL   = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END = 10'(H_VIS);
  localparam logic [9:0] V_VIS_END = 10'(V_VIS);
  localparam logic [9:0] HS_FIRST  = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST   = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST  = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST   = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [7:0] X_LIMIT   = 8'(X_SCREEN_PIXELS);
  localparam logic [6:0] Y_LIMIT   = 7'(Y_SCREEN_PIXELS);
  localparam int         MEM_DEPTH = 32768;

  // Row-major address with the *160 stride built from two shifts.
  function automatic logic [14:0] pixel_addr(input logic [7:0] col, input logic [6:0] row);
    return {1'b0, row, 7'b000_0000} + {3'b000, row, 5'b0_0000} + {7'b000_0000, col};
  endfunction

  logic [2:0]  mem_r [0:MEM_DEPTH-1];
  logic        pix_en_r;
  logic [9:0]  hcount_r;
  logic [9:0]  vcount_r;
  logic [7:0]  rd_col_s;
  logic [6:0]  rd_row_s;
  logic [14:0] rd_addr_s;
  logic [14:0] wr_addr_s;
  logic        wr_en_s;
  logic        vis_s;
  logic        hs_s;
  logic        vs_s;
  logic [2:0]  rd_data_r;
  logic        vis_d1_r;
  logic        hs_d1_r;
  logic        vs_d1_r;

  assign wr_addr_s = pixel_addr(x, y);
`ifdef PLOT_CLIP_EN
  assign wr_en_s   = plot && (x < X_LIMIT) && (y < Y_LIMIT);
`else
  assign wr_en_s   = plot;
`endif

  // Rows beyond 127 only occur during vertical blanking, so the 7-bit row truncation never shows.
  assign rd_col_s  = 8'(hcount_r >> SCALE_SHIFT);
  assign rd_row_s  = 7'(vcount_r >> SCALE_SHIFT);
  assign rd_addr_s = pixel_addr(rd_col_s, rd_row_s);
  assign vis_s     = (hcount_r < H_VIS_END) && (vcount_r < V_VIS_END) &&
                     (rd_col_s < X_LIMIT) && (rd_row_s < Y_LIMIT);
  assign hs_s      = !((hcount_r >= HS_FIRST) && (hcount_r <= HS_LAST));
  assign vs_s      = !((vcount_r >= VS_FIRST) && (vcount_r <= VS_LAST));

  assign vga_clk    = pix_en_r;
  assign vga_sync_n = 1'b0;

  // Plot write port; framebuffer contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= colour;
    end
  end

  // Registered RAM read (read-before-write on an address collision).
  always_ff @(posedge clk) begin
    if (pix_en_r) begin
      rd_data_r <= mem_r[rd_addr_s];
    end
  end

  // Pixel enable, scan counters and the sync/blank delay line aligned with the RAM read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_en_r    <= 1'b0;
      hcount_r    <= 10'd0;
      vcount_r    <= 10'd0;
      vis_d1_r    <= 1'b0;
      hs_d1_r     <= 1'b1;
      vs_d1_r     <= 1'b1;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= 8'h00;
      vga_g       <= 8'h00;
      vga_b       <= 8'h00;
      frame_start <= 1'b0;
    end else begin
      pix_en_r    <= ~pix_en_r;
      frame_start <= pix_en_r && (hcount_r == H_LAST) && (vcount_r == V_LAST);
      if (pix_en_r) begin
        if (hcount_r == H_LAST) begin
          hcount_r <= 10'd0;
          if (vcount_r == V_LAST) begin
            vcount_r <= 10'd0;
          end else begin
            vcount_r <= vcount_r + 10'd1;
          end
        end else begin
          hcount_r <= hcount_r + 10'd1;
        end
        vis_d1_r    <= vis_s;
        hs_d1_r     <= hs_s;
        vs_d1_r     <= vs_s;
        vga_hs      <= hs_d1_r;
        vga_vs      <= vs_d1_r;
        vga_blank_n <= vis_d1_r;
        vga_r       <= (vis_d1_r && rd_data_r[2]) ? 8'hFF : 8'h00;
        vga_g       <= (vis_d1_r && rd_data_r[1]) ? 8'hFF : 8'h00;
        vga_b       <= (vis_d1_r && rd_data_r[0]) ? 8'hFF : 8'h00;
      end
    end
  end

endmodule
